// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the TX feeder handshake state encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy, empty and full flags.
// Flush clears pointers and count; a push during flush is dropped.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage has no reset so it can map onto a RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte buffer ahead of the UART transmitter: queues producer bytes and issues them one at a time.
// Define UART_TX_FEEDER_STATS_EN to add high_water and drop_cnt outputs.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   wr_ready,
  input  logic                   flush,
  output logic                   tx_start,
  output logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_done,
  output logic                   busy,
`ifdef UART_TX_FEEDER_STATS_EN
  output logic [CNT_W-1:0]       high_water,
  output logic [15:0]            drop_cnt,
`endif
  output logic [CNT_W-1:0]       count,
  output logic                   empty,
  output logic                   full
);

  feeder_state_e          state;
  logic                   fifo_pop;
  logic [UART_DATA_W-1:0] fifo_rd_data;

  assign wr_ready = !full;
  assign fifo_pop = (state == IDLE) && !empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (wr_valid),
    .wr_data (wr_data),
    .pop     (fifo_pop),
    .flush   (flush),
    .rd_data (fifo_rd_data),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  // Launch FSM: one byte in flight at a time, next pop only after tx_done returns us to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            tx_data  <= fifo_rd_data;
            tx_start <= 1'b1;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          tx_start <= 1'b0;
          state    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          tx_start <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FEEDER_STATS_EN
  // High-water survives flush; drop counter saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      high_water <= '0;
      drop_cnt   <= '0;
    end else begin
      if (count > high_water) begin
        high_water <= count;
      end
      if (wr_valid && !wr_ready && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: scoreboard of accepted bytes against launched bytes.
module tb_uart_tx_feeder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             reset;
  logic             wr_valid;
  logic [7:0]       wr_data;
  logic             wr_ready;
  logic             flush;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_done;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
`ifdef UART_TX_FEEDER_STATS_EN
  logic [CNT_W-1:0] high_water;
  logic [15:0]      drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  logic [7:0] sb [$];
  logic [7:0] last_launched = 8'h00;

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .flush      (flush),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .busy       (busy),
`ifdef UART_TX_FEEDER_STATS_EN
    .high_water (high_water),
    .drop_cnt   (drop_cnt),
`endif
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    int n = 0;
    while (!wr_ready && n < 50) begin
      tick();
      n++;
    end
    if (!wr_ready) check("wr_ready_timeout", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1;
    wr_data  = b;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_done(input int gap);
    repeat (gap) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  // Scoreboard: record accepted bytes, compare each launch, and check tx_data stability while busy.
  always @(negedge clk) begin
    if (tx_start) begin
      n_start++;
      if (sb.size() == 0) begin
        check("unexpected_start", 32'(tx_start), 32'd0);
      end else begin
        check("tx_data_order", 32'(tx_data), 32'(sb.pop_front()));
      end
      last_launched = tx_data;
    end else if (busy) begin
      check("tx_data_stable", 32'(tx_data), 32'(last_launched));
    end
    if (reset || flush) begin
      sb.delete();
    end else if (wr_valid && wr_ready) begin
      sb.push_back(wr_data);
    end
  end

  initial begin
    int s0;
    reset = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; flush = 1'b0; tx_done = 1'b0;
    repeat (3) tick();
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data",  32'(tx_data),  32'h00);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_full",     32'(full),     32'd0);
    reset = 1'b0;
    repeat (2) tick();

    // Single byte: push edge, pop edge, then start pulse for one cycle
    s0 = n_start;
    write_byte(8'hA5);
    check("single_count1",   32'(count),    32'd1);
    check("single_no_start", 32'(tx_start), 32'd0);
    tick();
    check("single_start",    32'(tx_start), 32'd1);
    check("single_data",     32'(tx_data),  32'hA5);
    check("single_busy",     32'(busy),     32'd1);
    check("single_count0",   32'(count),    32'd0);
    tick();
    check("single_start_off", 32'(tx_start), 32'd0);
    check("single_busy_hold", 32'(busy),     32'd1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("single_idle_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    check("single_one_start", 32'(n_start - s0), 32'd1);

    // Burst: 17 writes leave 16 queued behind the in-flight byte
    s0 = n_start;
    for (int i = 1; i <= 17; i++) write_byte(8'(i));
    check("burst_full",     32'(full),     32'd1);
    check("burst_count",    32'(count),    32'd16);
    check("burst_wr_ready", 32'(wr_ready), 32'd0);
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    repeat (3) tick();
    wr_valid = 1'b0;
    check("burst_stall_count", 32'(count), 32'd16);
    for (int i = 0; i < 17; i++) pulse_done(159);
    repeat (20) tick();
    check("burst_starts",   32'(n_start - s0), 32'd17);
    check("burst_sb_empty", 32'(sb.size()),    32'd0);
    check("burst_empty",    32'(empty),        32'd1);
    check("burst_busy",     32'(busy),         32'd0);

    // Simultaneous push and pop with three queued
    write_byte(8'h30);
    write_byte(8'h31);
    write_byte(8'h32);
    write_byte(8'h33);
    check("pp_count3_before", 32'(count), 32'd3);
    tx_done = 1'b1;
    tick();
    tx_done  = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h34;
    tick();
    wr_valid = 1'b0;
    check("pp_count3_after", 32'(count),    32'd3);
    check("pp_start",        32'(tx_start), 32'd1);
    for (int i = 0; i < 4; i++) pulse_done(10);
    repeat (10) tick();
    check("pp_sb_empty", 32'(sb.size()), 32'd0);

    // Flush while 8'h11 is in flight; a coincident push is dropped
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    repeat (2) tick();
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h44;
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_busy",  32'(busy),  32'd1);
    s0 = n_start;
    pulse_done(3);
    check("flush_done_busy", 32'(busy), 32'd0);
    repeat (20) tick();
    check("flush_no_start", 32'(n_start - s0), 32'd0);

    // Reset during WAIT_DONE with five queued
    for (int i = 0; i < 6; i++) write_byte(8'h50 + 8'(i));
    repeat (2) tick();
    check("rstmid_count5", 32'(count), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_tx_start", 32'(tx_start), 32'd0);
    check("rstmid_busy",     32'(busy),     32'd0);
    check("rstmid_count",    32'(count),    32'd0);
    check("rstmid_empty",    32'(empty),    32'd1);
    check("rstmid_wr_ready", 32'(wr_ready), 32'd1);
    s0 = n_start;
    pulse_done(2);
    repeat (10) tick();
    check("rstmid_no_start", 32'(n_start - s0), 32'd0);

`ifdef UART_TX_FEEDER_STATS_EN
    for (int i = 0; i < 17; i++) write_byte(8'h60 + 8'(i));
    wr_valid = 1'b1;
    wr_data  = 8'h7F;
    repeat (4) tick();
    wr_valid = 1'b0;
    tick();
    check("stats_high_water", 32'(high_water), 32'd16);
    check("stats_drop_cnt",   32'(drop_cnt),   32'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("stats_hw_kept", 32'(high_water), 32'd16);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
